axi4_slave_wrapper: RTL

- AXI4-subset responder holding two SZ-bit operands, A at address 0 and B at address 1, and returning their 2*SZ-bit unsigned product.
- Operands arrive as fixed 4-beat write bursts, least-significant byte first.
- The product leaves as one 8-beat read burst, LSB first.
- Sits opposite the multiplier master wrapper on the same bus.

---
 rtl/axi4_mult_pkg.sv | 24 ++
 rtl/axi4_slave_wrapper_if.sv | 35 +++
 rtl/axi4_mult_core.sv | 26 ++
 rtl/axi4_slave_wrapper.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/axi4_mult_pkg.sv
// Shared constants and FSM state types for the AXI4-subset multiplier responder.
package axi4_mult_pkg;

    localparam int unsigned WBEATS = 4;
    localparam int unsigned RBEATS = 8;

    localparam int unsigned ADDR_A = 0;
    localparam int unsigned ADDR_B = 1;

    localparam logic RESP_OK  = 1'b1;
    localparam logic RESP_ERR = 1'b0;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wstate_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } rstate_e;

endpackage

// File: rtl/axi4_slave_wrapper_if.sv
// AXI4-subset bus between the multiplier master wrapper and this responder.
interface axi4_slave_wrapper_if #(
    parameter int unsigned ASZ = 2,
    parameter int unsigned DSZ = 8
);
    logic [ASZ-1:0] awaddr;
    logic           awvalid;
    logic           awready;
    logic [DSZ-1:0] wdata;
    logic           wvalid;
    logic           wready;
    logic           wlast;
    logic           bresp;
    logic           bvalid;
    logic           bready;
    logic [ASZ-1:0] araddr;
    logic           arvalid;
    logic           arready;
    logic [DSZ-1:0] rdata;
    logic           rvalid;
    logic           rready;
    logic           rlast;
    logic           rresp;

    modport master (
        output awaddr, awvalid, wdata, wvalid, wlast, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rvalid, rlast, rresp
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, wlast, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rvalid, rlast, rresp
    );

endinterface

// File: rtl/axi4_mult_core.sv
// Registered SZ x SZ unsigned multiplier; prod_valid drops for the cycle after a commit.
module axi4_mult_core #(
    parameter int unsigned SZ = 32
) (
    input  logic              clk,
    input  logic              _rst,
    input  logic              commit,
    input  logic [SZ-1:0]     a,
    input  logic [SZ-1:0]     b,
    output logic [2*SZ-1:0]   product,
    output logic              prod_valid
);

    localparam int unsigned PW = 2 * SZ;

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            product    <= '0;
            prod_valid <= 1'b1;
        end else begin
            product    <= PW'(a) * PW'(b);
            prod_valid <= ~commit;
        end
    end

endmodule

// File: rtl/axi4_slave_wrapper.sv
// AXI4-subset responder: operands A/B arrive as 4-beat write bursts, product leaves as an 8-beat read burst.
module axi4_slave_wrapper
    import axi4_mult_pkg::*;
#(
    parameter int unsigned SZ  = 32,
    parameter int unsigned ASZ = 2,
    parameter int unsigned DSZ = 8
) (
    input  logic                 clk,
    input  logic                 _rst,
    axi4_slave_wrapper_if.slave  bus,
    output logic [SZ-1:0]        a,
    output logic [SZ-1:0]        b
);

    localparam int unsigned PW  = 2 * SZ;
    localparam int unsigned WCW = $clog2(WBEATS + 1);
    localparam int unsigned WIW = $clog2(WBEATS);
    localparam int unsigned RCW = $clog2(RBEATS);

    // Write side state and registered outputs
    wstate_e                      w_state, w_state_nxt;
    logic                         sel_b, sel_b_nxt;
    logic                         bad, bad_nxt, bad_fin;
    logic [WCW-1:0]               wbeat, wbeat_nxt;
    logic [WBEATS-1:0][DSZ-1:0]   shadow, shadow_nxt;
    logic                         awready, awready_nxt;
    logic                         wready, wready_nxt;
    logic                         bvalid, bvalid_nxt;
    logic                         bresp, bresp_nxt;
    logic [SZ-1:0]                a_nxt, b_nxt;
    logic                         commit;

    // Read side state and registered outputs
    rstate_e                      r_state, r_state_nxt;
    logic [PW-1:0]                rshift, rshift_nxt;
    logic                         rerr, rerr_nxt;
    logic [RCW-1:0]               rbeat, rbeat_nxt;
    logic                         arready, arready_nxt;
    logic                         rvalid, rvalid_nxt;
    logic                         rlast, rlast_nxt;
    logic [DSZ-1:0]               rdata, rdata_nxt;
    logic                         rresp, rresp_nxt;

    logic [PW-1:0]                product;
    logic                         prod_valid;

    axi4_mult_core #(.SZ(SZ)) u_core (
        .clk        (clk),
        ._rst       (_rst),
        .commit     (commit),
        .a          (a),
        .b          (b),
        .product    (product),
        .prod_valid (prod_valid)
    );

    assign bus.awready = awready;
    assign bus.wready  = wready;
    assign bus.bvalid  = bvalid;
    assign bus.bresp   = bresp;
    assign bus.arready = arready;
    assign bus.rvalid  = rvalid;
    assign bus.rlast   = rlast;
    assign bus.rdata   = rdata;
    assign bus.rresp   = rresp;

    // Write FSM next state; the final beat merges into the shadow before committing it
    always_comb begin
        w_state_nxt = w_state;
        sel_b_nxt   = sel_b;
        bad_nxt     = bad;
        bad_fin     = bad;
        wbeat_nxt   = wbeat;
        shadow_nxt  = shadow;
        awready_nxt = awready;
        wready_nxt  = wready;
        bvalid_nxt  = bvalid;
        bresp_nxt   = bresp;
        a_nxt       = a;
        b_nxt       = b;
        commit      = 1'b0;
        case (w_state)
            W_IDLE: begin
                if (bus.awvalid && awready) begin
                    w_state_nxt = W_DATA;
                    sel_b_nxt   = (bus.awaddr == ASZ'(ADDR_B));
                    bad_nxt     = (bus.awaddr > ASZ'(ADDR_B));
                    wbeat_nxt   = '0;
                    awready_nxt = 1'b0;
                    wready_nxt  = 1'b1;
                end
            end
            W_DATA: begin
                if (bus.wvalid && wready) begin
                    if (wbeat < WCW'(WBEATS)) begin
                        shadow_nxt[wbeat[WIW-1:0]] = bus.wdata;
                        wbeat_nxt = wbeat + WCW'(1);
                    end
                    if (bus.wlast) begin
                        bad_fin     = bad || (wbeat != WCW'(WBEATS - 1));
                        w_state_nxt = W_RESP;
                        wready_nxt  = 1'b0;
                        bvalid_nxt  = 1'b1;
                        bresp_nxt   = bad_fin ? RESP_ERR : RESP_OK;
                        if (!bad_fin) begin
                            commit = 1'b1;
                            if (sel_b) b_nxt = shadow_nxt;
                            else       a_nxt = shadow_nxt;
                        end
                    end
                end
            end
            W_RESP: begin
                if (bvalid && bus.bready) begin
                    w_state_nxt = W_IDLE;
                    bvalid_nxt  = 1'b0;
                    awready_nxt = 1'b1;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            w_state <= W_IDLE;
            sel_b   <= 1'b0;
            bad     <= 1'b0;
            wbeat   <= '0;
            shadow  <= '0;
            awready <= 1'b1;
            wready  <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= RESP_ERR;
            a       <= '0;
            b       <= '0;
        end else begin
            w_state <= w_state_nxt;
            sel_b   <= sel_b_nxt;
            bad     <= bad_nxt;
            wbeat   <= wbeat_nxt;
            shadow  <= shadow_nxt;
            awready <= awready_nxt;
            wready  <= wready_nxt;
            bvalid  <= bvalid_nxt;
            bresp   <= bresp_nxt;
            a       <= a_nxt;
            b       <= b_nxt;
        end
    end

    // Read FSM next state; arready tracks the multiplier's valid flag while idle
    always_comb begin
        r_state_nxt = r_state;
        rshift_nxt  = rshift;
        rerr_nxt    = rerr;
        rbeat_nxt   = rbeat;
        arready_nxt = arready;
        rvalid_nxt  = rvalid;
        rlast_nxt   = rlast;
        rdata_nxt   = rdata;
        rresp_nxt   = rresp;
        case (r_state)
            R_IDLE: begin
                arready_nxt = ~commit;
                if (bus.arvalid && arready && prod_valid) begin
                    r_state_nxt = R_DATA;
                    rshift_nxt  = product;
                    rerr_nxt    = (bus.araddr != ASZ'(ADDR_A));
                    rbeat_nxt   = '0;
                    arready_nxt = 1'b0;
                    rvalid_nxt  = 1'b1;
                    rlast_nxt   = 1'b0;
                    rdata_nxt   = rerr_nxt ? '0 : product[DSZ-1:0];
                    rresp_nxt   = rerr_nxt ? RESP_ERR : RESP_OK;
                end
            end
            R_DATA: begin
                if (rvalid && bus.rready) begin
                    if (rlast) begin
                        r_state_nxt = R_IDLE;
                        rvalid_nxt  = 1'b0;
                        rlast_nxt   = 1'b0;
                        rdata_nxt   = '0;
                        arready_nxt = ~commit;
                    end else begin
                        rshift_nxt = rshift >> DSZ;
                        rbeat_nxt  = rbeat + RCW'(1);
                        rlast_nxt  = (rbeat == RCW'(RBEATS - 2));
                        rdata_nxt  = rerr ? '0 : rshift_nxt[DSZ-1:0];
                    end
                end
            end
            default: r_state_nxt = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_state <= R_IDLE;
            rshift  <= '0;
            rerr    <= 1'b0;
            rbeat   <= '0;
            arready <= 1'b1;
            rvalid  <= 1'b0;
            rlast   <= 1'b0;
            rdata   <= '0;
            rresp   <= RESP_ERR;
        end else begin
            r_state <= r_state_nxt;
            rshift  <= rshift_nxt;
            rerr    <= rerr_nxt;
            rbeat   <= rbeat_nxt;
            arready <= arready_nxt;
            rvalid  <= rvalid_nxt;
            rlast   <= rlast_nxt;
            rdata   <= rdata_nxt;
            rresp   <= rresp_nxt;
        end
    end

endmodule
